// File: rtl/fetch_if.sv
// Fetch-side bundle: ROM read port, redirect strobe and the instruction handshake to decode.
// "master" is the sequencer side; "slave" is the environment (ROM + branch unit + decode).
interface fetch_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_data, instr_ready,
    output mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_data, instr_ready,
    input  mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer over a 1-cycle synchronous ROM; zero-bubble redirects, stall-hold on !instr_ready.
// Optional macro FETCH_PERF_CNT_EN adds a saturating accepted-instruction counter on fetch_count.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  fetch_if.master     bus,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  handshake;

  assign pc_inc = req_pc + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_pc  <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_pc  <= addr;
    end
  end

  // req_pc always tracks the address just sent to the ROM, so holding it re-reads the same word.
  always_comb begin
    state_d   = state_q;
    addr      = req_pc;
    valid     = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) addr = bus.redirect_pc;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          addr = bus.redirect_pc;
          if (!en) state_d = HALT;
        end else begin
          valid = 1'b1;
          if (bus.instr_ready) begin
            addr      = pc_inc;
            handshake = 1'b1;
            if (!en) state_d = HALT;
          end
        end
      end
      HALT: begin
        if (bus.redirect_valid) addr = bus.redirect_pc;
        if (en) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) addr = RESET_PC;
  end

  assign bus.mem_addr    = addr;
  assign bus.instr_valid = valid;
  assign bus.instr       = bus.mem_data;
  assign bus.instr_pc    = req_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (handshake && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign fetch_count      = '0;
`endif

endmodule
